// File: rtl/udp_payload_trailer_if.sv
// ----------------------------------------------------------------------------
// udp_payload_trailer_if
// Groups the upstream FIFO read port (first-word-fall-through) and the
// downstream FIFO write port used by udp_payload_trailer.
//   in_rd_en   : pop request to the upstream FIFO
//   in_empty   : upstream FIFO empty
//   in_dout    : upstream head byte
//   in_rd_sof  : head byte is start of frame
//   in_rd_eof  : head byte is end of frame
//   out_wr_en  : write strobe to the downstream FIFO
//   out_din    : byte to write
//   out_wr_sof : start of frame, qualified by out_wr_en
//   out_wr_eof : end of frame, qualified by out_wr_en
//   out_full   : downstream FIFO full
// Modport slave is the trailer block, master is the FIFO side / bench.
// ----------------------------------------------------------------------------
interface udp_payload_trailer_if;
   logic       in_rd_en;
   logic       in_empty;
   logic [7:0] in_dout;
   logic       in_rd_sof;
   logic       in_rd_eof;
   logic       out_wr_en;
   logic [7:0] out_din;
   logic       out_wr_sof;
   logic       out_wr_eof;
   logic       out_full;

   modport slave (
      output in_rd_en,
      input  in_empty,
      input  in_dout,
      input  in_rd_sof,
      input  in_rd_eof,
      output out_wr_en,
      output out_din,
      output out_wr_sof,
      output out_wr_eof,
      input  out_full
   );

   modport master (
      input  in_rd_en,
      output in_empty,
      output in_dout,
      output in_rd_sof,
      output in_rd_eof,
      input  out_wr_en,
      input  out_din,
      input  out_wr_sof,
      input  out_wr_eof,
      output out_full
   );
endinterface

// File: rtl/udp_payload_trailer.sv
// ----------------------------------------------------------------------------
// udp_payload_trailer
// Drains parsed payload frames from an upstream FWFT FIFO and rewrites them
// into a downstream FIFO, passing payload bytes through with zero latency and
// appending a 4-byte trailer: payload length (16 bit) and the complement of
// the RFC 1071 ones'-complement sum. Stray bytes outside a frame are dropped,
// truncated / oversize frames are flagged, and wrapping status counters are
// exposed.
// Ports:
//   clk         : clock
//   reset       : synchronous active-high reset
//   bus         : FIFO read/write ports (udp_payload_trailer_if.slave)
//   frame_count : frames completed
//   drop_count  : stray bytes discarded
//   err_count   : truncated or oversize frames
// Parameters:
//   TRAILER_EN  : 0 forwards frames unchanged (eof on last payload byte)
//   CNT_WIDTH   : width of the status counters
// ----------------------------------------------------------------------------
module udp_payload_trailer #(
   parameter bit TRAILER_EN = 1'b1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   udp_payload_trailer_if.slave   bus,
   output logic [CNT_WIDTH-1:0]   frame_count,
   output logic [CNT_WIDTH-1:0]   drop_count,
   output logic [CNT_WIDTH-1:0]   err_count
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PAYLOAD = 3'd1,
      ST_LEN_HI  = 3'd2,
      ST_LEN_LO  = 3'd3,
      ST_CK_HI   = 3'd4,
      ST_CK_LO   = 3'd5,
      ST_DONE    = 3'd6
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // Ones'-complement 16-bit add with end-around carry. One fold suffices:
   // 0xFFFF + 0xFFFF = 0x1FFFE folds to 0xFFFF without a second carry.
   function automatic logic [15:0] csum_add(input logic [15:0] sum,
                                            input logic [15:0] word);
      logic [16:0] raw;
      raw      = {1'b0, sum} + {1'b0, word};
      csum_add = raw[15:0] + {15'd0, raw[16]};
   endfunction

   state_t      r_state;
   state_t      w_next;
   logic [15:0] r_len;
   logic [15:0] r_sum;
   logic        r_first;
   logic        r_err;
   logic        r_odd;      // next payload byte is the low byte of a word

   logic        w_rd_en;
   logic        w_wr_en;
   logic [7:0]  w_din;
   logic        w_sof;
   logic        w_eof;
   logic        w_start;    // IDLE sees a frame start
   logic        w_take;     // payload byte popped and written
   logic        w_trunc;    // new sof arrived before eof
   logic        w_drop;     // stray byte popped in IDLE
   logic        w_done;

   logic [15:0] w_ck;
   logic [15:0] w_word;

   assign w_ck   = ~r_sum;
   // Byte-wise accumulation is equivalent to word accumulation because the
   // ones'-complement sum is associative; odd frames are padded implicitly.
   assign w_word = r_odd ? {8'h00, bus.in_dout} : {bus.in_dout, 8'h00};

   // Next-state and combinational FIFO port outputs.
   always_comb begin
      w_next  = r_state;
      w_rd_en = 1'b0;
      w_wr_en = 1'b0;
      w_din   = 8'h00;
      w_sof   = 1'b0;
      w_eof   = 1'b0;
      w_start = 1'b0;
      w_take  = 1'b0;
      w_trunc = 1'b0;
      w_drop  = 1'b0;
      w_done  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (!bus.in_empty) begin
               if (bus.in_rd_sof) begin
                  // Frame head stays in the FIFO; PAYLOAD pops it.
                  w_start = 1'b1;
                  w_next  = ST_PAYLOAD;
               end else begin
                  w_rd_en = 1'b1;
                  w_drop  = 1'b1;
               end
            end else begin
               w_next = ST_IDLE;
            end
         end
         ST_PAYLOAD: begin
            if (!bus.in_empty) begin
               if (bus.in_rd_sof && !r_first) begin
                  // Truncated frame: leave the new head for the next frame.
                  w_trunc = 1'b1;
                  w_next  = TRAILER_EN ? ST_LEN_HI : ST_DONE;
               end else if (!bus.out_full) begin
                  w_rd_en = 1'b1;
                  w_wr_en = 1'b1;
                  w_take  = 1'b1;
                  w_din   = bus.in_dout;
                  w_sof   = r_first;
                  w_eof   = TRAILER_EN ? 1'b0 : bus.in_rd_eof;
                  if (bus.in_rd_eof) begin
                     w_next = TRAILER_EN ? ST_LEN_HI : ST_DONE;
                  end else begin
                     w_next = ST_PAYLOAD;
                  end
               end else begin
                  w_next = ST_PAYLOAD;
               end
            end else begin
               w_next = ST_PAYLOAD;
            end
         end
         ST_LEN_HI: begin
            if (!bus.out_full) begin
               w_wr_en = 1'b1;
               w_din   = r_len[15:8];
               w_next  = ST_LEN_LO;
            end else begin
               w_next = ST_LEN_HI;
            end
         end
         ST_LEN_LO: begin
            if (!bus.out_full) begin
               w_wr_en = 1'b1;
               w_din   = r_len[7:0];
               w_next  = ST_CK_HI;
            end else begin
               w_next = ST_LEN_LO;
            end
         end
         ST_CK_HI: begin
            if (!bus.out_full) begin
               w_wr_en = 1'b1;
               w_din   = w_ck[15:8];
               w_next  = ST_CK_LO;
            end else begin
               w_next = ST_CK_HI;
            end
         end
         ST_CK_LO: begin
            if (!bus.out_full) begin
               w_wr_en = 1'b1;
               w_din   = w_ck[7:0];
               w_eof   = 1'b1;
               w_next  = ST_DONE;
            end else begin
               w_next = ST_CK_LO;
            end
         end
         ST_DONE: begin
            w_done = 1'b1;
            w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   assign bus.in_rd_en   = w_rd_en;
   assign bus.out_wr_en  = w_wr_en;
   assign bus.out_din    = w_din;
   assign bus.out_wr_sof = w_sof;
   assign bus.out_wr_eof = w_eof;

   // State register, frame accumulators and status counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_len       <= 16'd0;
         r_sum       <= 16'd0;
         r_first     <= 1'b0;
         r_err       <= 1'b0;
         r_odd       <= 1'b0;
         frame_count <= {CNT_WIDTH{1'b0}};
         drop_count  <= {CNT_WIDTH{1'b0}};
         err_count   <= {CNT_WIDTH{1'b0}};
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_first <= 1'b1;
         end else if (w_take) begin
            r_first <= 1'b0;
         end
         if (w_take) begin
            // Length saturates; counting past 0xFFFF marks the frame oversize.
            if (r_len == 16'hFFFF) begin
               r_err <= 1'b1;
            end else begin
               r_len <= r_len + 16'd1;
            end
            r_sum <= csum_add(r_sum, w_word);
            r_odd <= ~r_odd;
         end
         if (w_trunc) begin
            r_err <= 1'b1;
         end
         if (w_drop) begin
            drop_count <= drop_count + CNT_ONE;
         end
         if (w_done) begin
            frame_count <= frame_count + CNT_ONE;
            if (r_err) begin
               err_count <= err_count + CNT_ONE;
            end
            r_len <= 16'd0;
            r_sum <= 16'd0;
            r_err <= 1'b0;
            r_odd <= 1'b0;
         end
      end
   end

endmodule
